// File: rtl/input_logic_pkg.sv
// ---------------------------------------------------------------------------
// input_logic_pkg
// Shared types and constants for the front-panel input block.
//   state_t   : controller handshake FSM states
//   DATA_W    : width of the data switch bank
//   RDA_W     : width of the register-file peek address
//   *_RST     : released/idle levels restored by Reset
// ---------------------------------------------------------------------------
package input_logic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DATA_W = 10;
  localparam int RDA_W  = 3;

  localparam logic [DATA_W-1:0] SW_RST    = 10'd0;
  localparam logic [DATA_W-1:0] DATA_RST  = 10'd0;
  localparam logic              LOADN_RST = 1'b1;
  localparam logic              PEEK_RST  = 1'b1;

  // Busy is asserted while an instruction is outstanding at the controller.
  function automatic logic state_busy(input state_t s);
    return (s == ISSUE) || (s == WAIT);
  endfunction

endpackage

// File: rtl/input_logic_if.sv
// ---------------------------------------------------------------------------
// input_logic_if
// Front-panel / controller signal bundle.
//   master : drives SW, Loadn, PeekSW, Clr; observes Data, Run, Busy, Pkb, RDA1
//   slave  : the input block itself (mirror directions)
// ---------------------------------------------------------------------------
interface input_logic_if;
  import input_logic_pkg::*;

  logic [DATA_W-1:0] SW;
  logic              Loadn;
  logic              PeekSW;
  logic              Clr;
  logic [DATA_W-1:0] Data;
  logic              Run;
  logic              Busy;
  logic              Pkb;
  logic [RDA_W-1:0]  RDA1;

  modport master (
    output SW, Loadn, PeekSW, Clr,
    input  Data, Run, Busy, Pkb, RDA1
  );

  modport slave (
    input  SW, Loadn, PeekSW, Clr,
    output Data, Run, Busy, Pkb, RDA1
  );

endinterface

// File: rtl/input_logic_debouncer.sv
// ---------------------------------------------------------------------------
// input_logic_debouncer
// Synchronises one asynchronous button and accepts a new level only after
// DEBOUNCE_CYCLES consecutive synced samples that differ from the current one.
//   Clock, Reset : system clock, synchronous active-high reset
//   raw          : asynchronous bouncy button input
//   level        : debounced level
//   fall         : one-cycle pulse after level goes 1->0
// ---------------------------------------------------------------------------
module input_logic_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       count_r;
  logic                   stable_r;
  logic                   fall_r;
  logic                   synced_s;
  logic                   accept_s;

  assign synced_s = sync_r[SYNC_STAGES-1];
  // The sample that completes the run of differing samples is itself counted.
  assign accept_s = (synced_s != stable_r) && (count_r == CNT_LAST);

  // Input synchroniser chain, reset to the released level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Stability counter, accepted level and falling-edge pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stable_r <= RESET_LEVEL;
      count_r  <= {CNT_W{1'b0}};
      fall_r   <= 1'b0;
    end else if (synced_s == stable_r) begin
      count_r <= {CNT_W{1'b0}};
      fall_r  <= 1'b0;
    end else if (accept_s) begin
      stable_r <= synced_s;
      count_r  <= {CNT_W{1'b0}};
      fall_r   <= ~synced_s;
    end else begin
      count_r <= count_r + CNT_ONE;
      fall_r  <= 1'b0;
    end
  end

  assign level = stable_r;
  assign fall  = fall_r;

endmodule

// File: rtl/input_logic.sv
// ---------------------------------------------------------------------------
// input_logic
// Front-panel input block: synchronises the data switches, debounces Load and
// Peek, issues one Run per Load press with the switch value latched on Data,
// and holds Busy until the controller reports completion on Clr.
//   Clock, Reset : system clock, synchronous active-high reset
//   bus (slave)  : SW, Loadn, PeekSW, Clr in; Data, Run, Busy, Pkb, RDA1 out
// ---------------------------------------------------------------------------
module input_logic
  import input_logic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input_logic_if.slave bus
);

  logic [DATA_W-1:0] sw_sync_r [SYNC_STAGES];
  logic [DATA_W-1:0] sw_synced_s;
  logic [DATA_W-1:0] data_r;
  logic              load_level_s;
  logic              load_fall_s;
  logic              peek_level_s;
  logic              peek_fall_unused_s;
  state_t            state_r;
  state_t            state_next_s;
  logic              run_next_s;
  logic              busy_next_s;
  logic              run_r;
  logic              busy_r;
  logic              pkb_r;

  input_logic_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .RESET_LEVEL     (LOADN_RST)
  ) u_load_debouncer (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.Loadn),
    .level (load_level_s),
    .fall  (load_fall_s)
  );

  input_logic_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .RESET_LEVEL     (PEEK_RST)
  ) u_peek_debouncer (
    .Clock (Clock),
    .Reset (Reset),
    .raw   (bus.PeekSW),
    .level (peek_level_s),
    .fall  (peek_fall_unused_s)
  );

  // Shared synchroniser for the whole switch bank.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= SW_RST;
      end
    end else begin
      sw_sync_r[0] <= bus.SW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= sw_sync_r[i-1];
      end
    end
  end

  assign sw_synced_s = sw_sync_r[SYNC_STAGES-1];

  // Next-state logic of the press/complete handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_fall_s) state_next_s = ISSUE;
        else             state_next_s = IDLE;
      end
      ISSUE: begin
        if (bus.Clr) state_next_s = HOLD;
        else         state_next_s = WAIT;
      end
      WAIT: begin
        if (bus.Clr) state_next_s = HOLD;
        else         state_next_s = WAIT;
      end
      HOLD: begin
        // A held button must be released before another press can issue.
        if (load_level_s) state_next_s = IDLE;
        else              state_next_s = HOLD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the next state so Run/Busy can be registered.
  always_comb begin
    run_next_s  = 1'b0;
    busy_next_s = state_busy(state_next_s);
    case (state_next_s)
      ISSUE:   run_next_s = 1'b1;
      default: run_next_s = 1'b0;
    endcase
  end

  // State register, registered Run/Busy and Data capture on issue.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
      run_r   <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= DATA_RST;
    end else begin
      state_r <= state_next_s;
      run_r   <= run_next_s;
      busy_r  <= busy_next_s;
      if ((state_r == IDLE) && (state_next_s == ISSUE)) begin
        data_r <= sw_synced_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Registered copy of the debounced peek selector.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pkb_r <= PEEK_RST;
    end else begin
      pkb_r <= peek_level_s;
    end
  end

  assign bus.Data = data_r;
  assign bus.Run  = run_r;
  assign bus.Busy = busy_r;
  assign bus.Pkb  = pkb_r;
  assign bus.RDA1 = sw_synced_s[RDA_W-1:0];

endmodule
